fifo_wr_ctrl: RTL and testbench

Write-side controller of the FIFO: owns the head pointer, accepts producer pushes, and drives the memory write enable and address. It tracks occupancy from accepted pushes and the accepted-pop strobe returned by the read-side pointer, and generates `full_flag`, `empty_flag` and optional `almost_full` from a three-state occupancy FSM. It sits between the producer and the FIFO memory, alongside `pointer_rd`, and supplies the `empty_flag` that the read side consumes.

---
 rtl/fifo_pkg.sv | 17 +
 rtl/fifo_wr_ctrl_if.sv | 43 ++++
 rtl/fifo_occupancy.sv | 42 ++++
 rtl/fifo_wr_ctrl.sv | 112 +++++++++++
 tb/tb_fifo_wr_ctrl.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared sizing and types for the FIFO write-side controller.
// Holds the default depth, the address/count types sized from it, and the
// occupancy state encoding.
package fifo_pkg;

  localparam int W_DEPTH = 8;

  typedef logic [$clog2(W_DEPTH)-1:0]   addr_t;
  typedef logic [$clog2(W_DEPTH+1)-1:0] cnt_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_PART  = 2'd1,
    ST_FULL  = 2'd2
  } wr_state_t;

endpackage : fifo_pkg

// File: rtl/fifo_wr_ctrl_if.sv
// fifo_wr_ctrl_if: producer/read-side handshake and memory write port of the
// FIFO write controller. The almost_full signal exists only when
// FIFO_ALMOST_FULL_EN is defined.
interface fifo_wr_ctrl_if #(
  parameter int W_DEPTH = fifo_pkg::W_DEPTH
);
  localparam int AW = (W_DEPTH > 1) ? $clog2(W_DEPTH) : 1;
  localparam int CW = $clog2(W_DEPTH + 1);

  logic          push;
  logic          pop_acc;
  logic          err_clr;
  logic          ena_wr;
  logic [AW-1:0] addr_wr;
  logic [CW-1:0] count;
  logic          full_flag;
  logic          empty_flag;
  logic          led_error;
`ifdef FIFO_ALMOST_FULL_EN
  logic          almost_full;
`endif

`ifdef FIFO_ALMOST_FULL_EN
  modport master (
    output push, pop_acc, err_clr,
    input  ena_wr, addr_wr, count, full_flag, empty_flag, led_error, almost_full
  );
  modport slave (
    input  push, pop_acc, err_clr,
    output ena_wr, addr_wr, count, full_flag, empty_flag, led_error, almost_full
  );
`else
  modport master (
    output push, pop_acc, err_clr,
    input  ena_wr, addr_wr, count, full_flag, empty_flag, led_error
  );
  modport slave (
    input  push, pop_acc, err_clr,
    output ena_wr, addr_wr, count, full_flag, empty_flag, led_error
  );
`endif

endinterface : fifo_wr_ctrl_if

// File: rtl/fifo_occupancy.sv
// fifo_occupancy: occupancy counter of the FIFO. Counts up on an accepted
// push, down on an accepted pop, holds when both or neither occur, and
// ignores pops while already empty.
module fifo_occupancy #(
  parameter int W_DEPTH = fifo_pkg::W_DEPTH,
  parameter int CW      = $clog2(W_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_inc,
  input  logic          i_dec,
  output logic [CW-1:0] o_count,
  output logic [CW-1:0] o_count_next
);

  logic [CW-1:0] r_count;
  logic          w_dec_eff;

  assign w_dec_eff = i_dec & (r_count != '0);

  // Next occupancy from the accepted push and the (saturated) pop.
  always_comb begin
    o_count_next = r_count;
    if (i_inc && !w_dec_eff) begin
      o_count_next = r_count + CW'(1);
    end else if (!i_inc && w_dec_eff) begin
      o_count_next = r_count - CW'(1);
    end
  end

  // Occupancy register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else begin
      r_count <= o_count_next;
    end
  end

  assign o_count = r_count;

endmodule : fifo_occupancy

// File: rtl/fifo_wr_ctrl.sv
// fifo_wr_ctrl: write-side controller of the FIFO. Owns the head pointer,
// gates producer pushes against the registered full flag, drives the memory
// write strobe/address, and keeps the EMPTY/PART/FULL occupancy state plus a
// sticky overflow error. Optional almost_full flag: FIFO_ALMOST_FULL_EN.
module fifo_wr_ctrl
  import fifo_pkg::*;
#(
  parameter int W_DEPTH  = fifo_pkg::W_DEPTH,
  parameter int AF_LEVEL = W_DEPTH - 2
) (
  input  logic           clk,
  input  logic           rst_n,
  fifo_wr_ctrl_if.slave  bus
);

  localparam int AW = (W_DEPTH > 1) ? $clog2(W_DEPTH) : 1;
  localparam int CW = $clog2(W_DEPTH + 1);

  logic [AW-1:0] r_head;
  wr_state_t     r_state;
  wr_state_t     w_state_next;
  logic          r_led_error;
  logic          w_full;
  logic          w_empty;
  logic          w_accept;
  logic          w_reject;
  logic [CW-1:0] w_count;
  logic [CW-1:0] w_count_next;

  assign w_full   = (r_state == ST_FULL);
  assign w_empty  = (r_state == ST_EMPTY);
  assign w_accept = bus.push & ~w_full;
  assign w_reject = bus.push & w_full;

  fifo_occupancy #(
    .W_DEPTH (W_DEPTH),
    .CW      (CW)
  ) u_occupancy (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_inc        (w_accept),
    .i_dec        (bus.pop_acc),
    .o_count      (w_count),
    .o_count_next (w_count_next)
  );

  // Head pointer advances on every accepted push and wraps by explicit compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head <= '0;
    end else if (w_accept) begin
      if (r_head == AW'(W_DEPTH - 1)) begin
        r_head <= '0;
      end else begin
        r_head <= r_head + AW'(1);
      end
    end
  end

  // Occupancy state decoded from the count the next edge will load.
  always_comb begin
    w_state_next = ST_PART;
    if (w_count_next == '0) begin
      w_state_next = ST_EMPTY;
    end else if (w_count_next == CW'(W_DEPTH)) begin
      w_state_next = ST_FULL;
    end
  end

  // Occupancy state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Sticky overflow error; a rejected push beats a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_led_error <= 1'b0;
    end else if (w_reject) begin
      r_led_error <= 1'b1;
    end else if (bus.err_clr) begin
      r_led_error <= 1'b0;
    end
  end

`ifdef FIFO_ALMOST_FULL_EN
  logic r_almost_full;

  // Almost-full flag registered alongside the other occupancy flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_almost_full <= 1'b0;
    end else begin
      r_almost_full <= (w_count_next >= CW'(AF_LEVEL));
    end
  end

  assign bus.almost_full = r_almost_full;
`endif

  assign bus.ena_wr     = w_accept;
  assign bus.addr_wr    = r_head;
  assign bus.count      = w_count;
  assign bus.full_flag  = w_full;
  assign bus.empty_flag = w_empty;
  assign bus.led_error  = r_led_error;

endmodule : fifo_wr_ctrl

// File: tb/tb_fifo_wr_ctrl.sv
// tb_fifo_wr_ctrl: table-driven and randomized bench for fifo_wr_ctrl,
// compared against an occupancy/pointer model kept here.
module tb_fifo_wr_ctrl;
  import fifo_pkg::*;

  localparam int W  = fifo_pkg::W_DEPTH;
  localparam int AF = W - 2;

  logic clk = 1'b0;
  logic rst_n;

  fifo_wr_ctrl_if #(.W_DEPTH(W)) bus ();

  fifo_wr_ctrl #(.W_DEPTH(W), .AF_LEVEL(AF)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic push, pop, clr;
    logic ena;
    int   addr, cnt;
    logic full, empty, err;
  } vec_t;

  vec_t vecs[$];
  int   nChecks = 0;
  int   nFails  = 0;

  // Model state: plain occupancy count, head index and error bit.
  int   mCount, mHead;
  logic mErr;

  function automatic void addVec(logic p, logic q, logic c, logic e, int a,
                                 int n, logic f, logic em, logic er);
    vec_t v;
    v.push = p; v.pop = q; v.clr = c; v.ena = e; v.addr = a; v.cnt = n;
    v.full = f; v.empty = em; v.err = er;
    vecs.push_back(v);
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    nChecks++;
    if (actual != expected) begin
      nFails++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic p, input logic q, input logic c);
    @(negedge clk);
    bus.push = p; bus.pop_acc = q; bus.err_clr = c;
    #1;
  endtask

  task automatic modelReset();
    mCount = 0; mHead = 0; mErr = 1'b0;
  endtask

  // Advance the model over the coming rising edge.
  task automatic clockEdge();
    bit accept, reject, popEff;
    @(posedge clk);
    accept = bus.push && (mCount < W);
    reject = bus.push && (mCount == W);
    popEff = bus.pop_acc && (mCount > 0);
    mCount = mCount + int'(accept) - int'(popEff);
    if (accept) mHead = (mHead + 1) % W;
    if (reject) mErr = 1'b1;
    else if (bus.err_clr) mErr = 1'b0;
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, "_ena"},   int'(bus.ena_wr),     int'(bus.push && mCount != W));
    checkOutput({tag, "_addr"},  int'(bus.addr_wr),    mHead);
    checkOutput({tag, "_cnt"},   int'(bus.count),      mCount);
    checkOutput({tag, "_full"},  int'(bus.full_flag),  int'(mCount == W));
    checkOutput({tag, "_empty"}, int'(bus.empty_flag), int'(mCount == 0));
    checkOutput({tag, "_err"},   int'(bus.led_error),  int'(mErr));
`ifdef FIFO_ALMOST_FULL_EN
    checkOutput({tag, "_af"},    int'(bus.almost_full), int'(mCount >= AF));
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    bus.push = 1'b0; bus.pop_acc = 1'b0; bus.err_clr = 1'b0;
    modelReset();

    // Directed sequence: fill, overflow, clear, full push+pop, drain, wrap, mid push+pop.
    for (int i = 0; i < W; i++) addVec(1, 0, 0, 1, i, i, 0, i == 0, 0);
    addVec(1, 0, 0, 0, 0, W, 1, 0, 0);
    addVec(0, 0, 0, 0, 0, W, 1, 0, 1);
    addVec(0, 0, 1, 0, 0, W, 1, 0, 1);
    addVec(0, 0, 0, 0, 0, W, 1, 0, 0);
    addVec(1, 1, 0, 0, 0, W, 1, 0, 0);
    addVec(0, 0, 0, 0, 0, W - 1, 0, 0, 1);
    addVec(0, 0, 1, 0, 0, W - 1, 0, 0, 1);
    for (int i = 0; i < W - 1; i++) addVec(0, 1, 0, 0, 0, W - 1 - i, 0, 0, 0);
    addVec(0, 1, 0, 0, 0, 0, 0, 1, 0);
    addVec(1, 0, 0, 1, 0, 0, 0, 1, 0);
    addVec(1, 0, 0, 1, 1, 1, 0, 0, 0);
    addVec(1, 0, 0, 1, 2, 2, 0, 0, 0);
    addVec(1, 0, 0, 1, 3, 3, 0, 0, 0);
    addVec(1, 1, 0, 1, 4, 4, 0, 0, 0);
    addVec(0, 0, 0, 0, 5, 4, 0, 0, 0);

    #3;
    checkOutput("rst_cnt",   int'(bus.count),      0);
    checkOutput("rst_empty", int'(bus.empty_flag), 1);
    checkOutput("rst_full",  int'(bus.full_flag),  0);
    checkOutput("rst_addr",  int'(bus.addr_wr),    0);
    checkOutput("rst_err",   int'(bus.led_error),  0);
    checkOutput("rst_ena",   int'(bus.ena_wr),     0);
    #9 rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].push, vecs[i].pop, vecs[i].clr);
      checkOutput($sformatf("v%0d_ena", i),   int'(bus.ena_wr),     int'(vecs[i].ena));
      checkOutput($sformatf("v%0d_addr", i),  int'(bus.addr_wr),    vecs[i].addr);
      checkOutput($sformatf("v%0d_cnt", i),   int'(bus.count),      vecs[i].cnt);
      checkOutput($sformatf("v%0d_full", i),  int'(bus.full_flag),  int'(vecs[i].full));
      checkOutput($sformatf("v%0d_empty", i), int'(bus.empty_flag), int'(vecs[i].empty));
      checkOutput($sformatf("v%0d_err", i),   int'(bus.led_error),  int'(vecs[i].err));
      clockEdge();
    end

    // Mid-run reset with count 5: everything returns to reset values at once.
    applyStimulus(1, 0, 0);
    clockEdge();
    applyStimulus(0, 0, 0);
    checkOutput("pre_rst_cnt", int'(bus.count), 5);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_cnt",   int'(bus.count),      0);
    checkOutput("mid_rst_empty", int'(bus.empty_flag), 1);
    checkOutput("mid_rst_addr",  int'(bus.addr_wr),    0);
    checkOutput("mid_rst_full",  int'(bus.full_flag),  0);
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 0, 0);
    checkOutput("post_rst_empty", int'(bus.empty_flag), 1);
    checkOutput("post_rst_addr",  int'(bus.addr_wr),    0);
    clockEdge();

`ifdef FIFO_ALMOST_FULL_EN
    // almost_full rises after the AF-th push and falls once count drops below it.
    for (int i = 0; i < AF; i++) begin
      applyStimulus(1, 0, 0);
      checkOutput($sformatf("af_rise%0d", i), int'(bus.almost_full), 0);
      clockEdge();
    end
    applyStimulus(0, 0, 0);
    checkOutput("af_high", int'(bus.almost_full), 1);
    clockEdge();
    applyStimulus(0, 1, 0);
    checkOutput("af_hold", int'(bus.almost_full), 1);
    clockEdge();
    applyStimulus(0, 0, 0);
    checkOutput("af_fall", int'(bus.almost_full), 0);
    clockEdge();
`endif

    // Randomized traffic: producer-heavy first half, consumer-heavy second half.
    for (int i = 0; i < 600; i++) begin
      int pPush;
      pPush = (i < 300) ? 75 : 30;
      applyStimulus($urandom_range(99) < pPush, $urandom_range(99) < (100 - pPush),
                    $urandom_range(99) < 10);
      checkModel($sformatf("r%0d", i));
      clockEdge();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule : tb_fifo_wr_ctrl
